// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-4 Booth issue/collect stage.
// Imported by the operand FIFO and the issue controller.
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUT     = 3'd5
  } state_e;

  function automatic int booth_timeout(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/booth_opnd_fifo.sv
// Two-entry operand-pair FIFO feeding the Booth core.
// Push is refused when full even if a pop happens in the same cycle.
module booth_opnd_fifo
  import booth_pkg::*;
#(
  parameter int DW = 2 * BOOTH_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue/collect controller for the radix-4 Booth multiplier core.
// Clears, starts and collects one op at a time, with a hang timeout.
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH   = BOOTH_WIDTH,
  parameter int TIMEOUT = booth_timeout(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_err,
  output logic               busy,
  output logic               mul_clr,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_mcand,
  output logic [WIDTH-1:0]   mul_mplier,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_prod
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ov_q, ov_d;
  logic                 oerr_q, oerr_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 push;
  logic                 pop;
  logic [2*WIDTH-1:0]   head;
  logic [1:0]           count;
  logic                 full;
  logic                 empty;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == ST_CAPTURE);

  booth_opnd_fifo #(
    .DW(2 * WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Head entry stays put until CAPTURE pops it, so operands hold through WAIT.
  assign mul_mcand  = head[2*WIDTH-1:WIDTH];
  assign mul_mplier = head[WIDTH-1:0];

  assign mul_clr   = ~rst_n | (state_q == ST_CLEAR);
  assign mul_start = (state_q == ST_LAUNCH);
  assign busy      = (state_q != ST_IDLE) | (count != 2'd0);
  assign out_valid = ov_q;
  assign out_err   = oerr_q;
  assign out_prod  = prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ov_d    = ov_q;
    oerr_d  = oerr_q;
    prod_d  = prod_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done seen on the last allowed cycle still wins over timeout.
        if (mul_done) begin
          err_d   = 1'b0;
          state_d = ST_CAPTURE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        prod_d  = err_q ? '0 : mul_prod;
        oerr_d  = err_q;
        ov_d    = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = empty ? ST_IDLE : ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      oerr_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      oerr_q  <= oerr_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a behavioural Booth core model.
// Results are collected at the negative edge and checked per scenario.
module tb_booth_issue_ctrl;

  localparam int W = 8;
  localparam int T = 4 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_prod;
  logic          out_err;
  logic          busy;
  logic          mul_clr;
  logic          mul_start;
  logic [W-1:0]  mul_mcand;
  logic [W-1:0]  mul_mplier;
  logic          mul_done;
  logic [2*W-1:0] mul_prod;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_issue_ctrl #(
    .WIDTH(W),
    .TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_err    (out_err),
    .busy       (busy),
    .mul_clr    (mul_clr),
    .mul_start  (mul_start),
    .mul_mcand  (mul_mcand),
    .mul_mplier (mul_mplier),
    .mul_done   (mul_done),
    .mul_prod   (mul_prod)
  );

  // Behavioural core: latency and hang latched at start; done sticky until clr.
  int              lat = 3;
  logic            hang = 1'b0;
  logic signed [W-1:0] ma = '0;
  logic signed [W-1:0] mb = '0;
  logic [2*W-1:0]  mprod_r = '0;
  logic            mdone_r = 1'b0;
  logic            mrun = 1'b0;
  logic            mh = 1'b0;
  int              mcnt = 0;

  assign mul_done = mdone_r;
  assign mul_prod = mprod_r;

  always @(posedge clk) begin
    if (mul_clr) begin
      mdone_r <= 1'b0;
      mrun    <= 1'b0;
    end else if (mul_start) begin
      mrun <= 1'b1;
      mcnt <= lat;
      mh   <= hang;
      ma   <= mul_mcand;
      mb   <= mul_mplier;
    end else if (mrun && !mh) begin
      if (mcnt <= 1) begin
        mrun    <= 1'b0;
        mdone_r <= 1'b1;
        mprod_r <= 16'(ma) * 16'(mb);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Monitor
  int   cyc = 0;
  int   start_cnt = 0;
  int   clr_cnt = 0;
  int   bad_order = 0;
  int   last_start = 0;
  logic clr_prev = 1'b0;
  logic [2*W-1:0] rq_prod[$];
  logic           rq_err[$];
  int             rq_dt[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_clr) clr_cnt++;
      if (mul_start) begin
        start_cnt++;
        last_start = cyc;
        if (!clr_prev) bad_order++;
      end
      clr_prev = mul_clr;
      if (out_valid && out_ready) begin
        rq_prod.push_back(out_prod);
        rq_err.push_back(out_err);
        rq_dt.push_back(cyc - last_start);
      end
    end else begin
      clr_prev = 1'b0;
    end
  end

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_res(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rq_prod.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int s0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start_cnt > s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (mul_clr !== 1'b1) begin
      errors++;
      $display("FAIL rst_clr: got %b want 1", mul_clr);
    end
    checks++;
    if ({out_valid, out_err, mul_start, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl: got %b want 0000",
               {out_valid, out_err, mul_start, busy});
    end
    checks++;
    if (out_prod !== 16'h0000) begin
      errors++;
      $display("FAIL rst_prod: got %h want 0000", out_prod);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mul_clr !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: in_ready=%b mul_clr=%b want 1/0",
               in_ready, mul_clr);
    end
  endtask

  task automatic test_basic;
    int s0, c0;
    bit ok;
    s0 = start_cnt;
    c0 = clr_cnt;
    lat = 3;
    push_op(8'd3, 8'd5);
    wait_res(1, 200, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: results=%0d want 1", rq_prod.size());
    end else begin
      checks++;
      if (rq_prod[0] !== 16'h000F || rq_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_prod: got %h err=%b want 000F err=0",
                 rq_prod[0], rq_err[0]);
      end
      void'(rq_prod.pop_front());
      void'(rq_err.pop_front());
      void'(rq_dt.pop_front());
    end
    checks++;
    if (start_cnt - s0 != 1 || clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL basic_pulses: starts=%0d clrs=%0d want 1/1",
               start_cnt - s0, clr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    push_op(8'h80, 8'h80);
    push_op(8'hF9, 8'd6);
    wait_res(2, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: results=%0d want 2", rq_prod.size());
    end else begin
      checks++;
      if (rq_prod[0] !== 16'h4000 || rq_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first: got %h want 4000", rq_prod[0]);
      end
      checks++;
      if (rq_prod[1] !== 16'hFFD6 || rq_err[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second: got %h want FFD6", rq_prod[1]);
      end
      rq_prod.delete();
      rq_err.delete();
      rq_dt.delete();
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [2*W-1:0] held;
    lat = 6;
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_op(8'd10, 8'd20);
    push_op(8'hFF, 8'hFF);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    push_op(8'd100, 8'hFD);
    repeat (20) @(negedge clk);
    held = out_prod;
    checks++;
    if (out_valid !== 1'b1 || out_prod !== 16'h00C8) begin
      errors++;
      $display("FAIL bp_hold: valid=%b prod=%h want 1/00C8",
               out_valid, out_prod);
    end
    checks++;
    if (in_ready !== 1'b0 || rq_prod.size() != 0) begin
      errors++;
      $display("FAIL bp_stall: in_ready=%b results=%0d want 0/0",
               in_ready, rq_prod.size());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (out_prod !== held || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: prod=%h valid=%b want 00C8/1",
               out_prod, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_res(3, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: results=%0d want 3", rq_prod.size());
    end else begin
      checks++;
      if (rq_prod[0] !== 16'h00C8 || rq_prod[1] !== 16'h0001 ||
          rq_prod[2] !== 16'hFED4) begin
        errors++;
        $display("FAIL bp_order: got %h %h %h want 00C8 0001 FED4",
                 rq_prod[0], rq_prod[1], rq_prod[2]);
      end
      rq_prod.delete();
      rq_err.delete();
      rq_dt.delete();
    end
    lat = 3;
  endtask

  task automatic test_sticky_done;
    bit ok;
    int s0;
    s0 = start_cnt;
    lat = 2;
    push_op(8'd5, 8'd7);
    wait_start(s0, ok);
    @(posedge clk); #1;
    lat = 20;
    push_op(8'hFE, 8'd9);
    wait_res(2, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sticky_timeout: results=%0d want 2", rq_prod.size());
    end else begin
      checks++;
      if (rq_prod[0] !== 16'h0023 || rq_prod[1] !== 16'hFFEE) begin
        errors++;
        $display("FAIL sticky_prod: got %h %h want 0023 FFEE",
                 rq_prod[0], rq_prod[1]);
      end
      rq_prod.delete();
      rq_err.delete();
      rq_dt.delete();
    end
    lat = 3;
  endtask

  task automatic test_timeout;
    bit ok;
    int s0;
    s0 = start_cnt;
    hang = 1'b1;
    push_op(8'd4, 8'd4);
    wait_start(s0, ok);
    @(posedge clk); #1;
    hang = 1'b0;
    push_op(8'd2, 8'd3);
    wait_res(2, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_timeout: results=%0d want 2", rq_prod.size());
    end else begin
      checks++;
      if (rq_err[0] !== 1'b1 || rq_prod[0] !== 16'h0000) begin
        errors++;
        $display("FAIL to_err: err=%b prod=%h want 1/0000",
                 rq_err[0], rq_prod[0]);
      end
      // start seen -> WAIT next edge -> T WAIT cycles -> CAPTURE -> valid
      checks++;
      if (rq_dt[0] != T + 2) begin
        errors++;
        $display("FAIL to_latency: got %0d want %0d", rq_dt[0], T + 2);
      end
      checks++;
      if (rq_err[1] !== 1'b0 || rq_prod[1] !== 16'h0006) begin
        errors++;
        $display("FAIL to_next: err=%b prod=%h want 0/0006",
                 rq_err[1], rq_prod[1]);
      end
      rq_prod.delete();
      rq_err.delete();
      rq_dt.delete();
    end
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    int s0;
    s0 = start_cnt;
    lat = 20;
    push_op(8'd9, 8'd9);
    wait_start(s0, ok);
    push_op(8'd1, 8'd2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_clr !== 1'b1 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_clr: clr=%b start=%b want 1/0", mul_clr, mul_start);
    end
    checks++;
    if ({out_valid, out_err, busy, in_ready} !== 4'b0001 ||
        out_prod !== 16'h0000) begin
      errors++;
      $display("FAIL mid_state: v/e/b/r=%b prod=%h want 0001/0000",
               {out_valid, out_err, busy, in_ready}, out_prod);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 3;
    repeat (60) @(negedge clk);
    checks++;
    if (rq_prod.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: results=%0d busy=%b want 0/0",
               rq_prod.size(), busy);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_sticky_done;
    test_timeout;
    test_reset_mid_op;
    checks++;
    if (bad_order != 0) begin
      errors++;
      $display("FAIL clr_before_start: got %0d bad starts want 0", bad_order);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
